// File: rtl/goertzel_pkg.sv
// Shared types and arithmetic helpers for the multi-bin Goertzel power block.
// The helpers carry operands at 64 bits, so ACC_W must be <= 64.
package goertzel_pkg;

  typedef enum logic [1:0] {StIdle, StFilter, StCalcA, StCalcB} state_e;

  // Q1.COEFF_BITS coefficients need a sign bit and one integer bit.
  localparam int unsigned CoeffExtraBits = 2;

  function automatic int unsigned coeff_width(input int unsigned coeff_bits);
    return coeff_bits + CoeffExtraBits;
  endfunction

  // Signed product with the fractional bits dropped; callers keep the low ACC_W bits.
  function automatic logic signed [63:0] mulc(input logic signed [63:0] a,
                                               input logic signed [63:0] c,
                                               input int unsigned frac);
    logic signed [127:0] pa;
    logic signed [127:0] pc;
    logic signed [127:0] p;
    pa = {{64{a[63]}}, a};
    pc = {{64{c[63]}}, c};
    p  = pa * pc;
    p  = p >>> frac;
    return p[63:0];
  endfunction

  function automatic logic [63:0] sq_sum_sat(input logic signed [63:0] re,
                                             input logic signed [63:0] im,
                                             input int unsigned pow_w);
    logic signed [127:0] re_w;
    logic signed [127:0] im_w;
    logic [128:0] sum;
    logic [128:0] lim;
    re_w = {{64{re[63]}}, re};
    im_w = {{64{im[63]}}, im};
    sum  = {1'b0, re_w * re_w} + {1'b0, im_w * im_w};
    lim  = (129'd1 << pow_w) - 129'd1;
    if (sum > lim) sum = lim;
    return sum[63:0];
  endfunction

endpackage

// File: rtl/goertzel_bin_filter.sv
// Second-order Goertzel recursion for one bin: s0 <= x + 2cos*s0 - s1, s1 <= s0.
module goertzel_bin_filter
  import goertzel_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned COEFF_BITS = 24,
  parameter int unsigned ACC_W      = 32,
  parameter int unsigned COEFF_W    = COEFF_BITS + 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic signed [COEFF_W-1:0] coeff,
  input  logic signed [DATA_W-1:0]  data,
  input  logic                      valid,
  output logic signed [ACC_W-1:0]   s0,
  output logic signed [ACC_W-1:0]   s1
);

  logic signed [63:0]      two_cos;
  logic signed [ACC_W-1:0] prod;
  logic signed [ACC_W-1:0] x_ext;
  logic signed [ACC_W-1:0] s0_next;

  // Doubling at 64 bits keeps 2*cos = 2.0 representable.
  assign two_cos = 64'(coeff) <<< 1;
  assign prod    = ACC_W'(mulc(two_cos, 64'(s0), COEFF_BITS));
  assign x_ext   = ACC_W'(data);
  assign s0_next = x_ext + prod - s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0 <= '0;
      s1 <= '0;
    end else if (clr) begin
      s0 <= '0;
      s1 <= '0;
    end else if (valid) begin
      s0 <= s0_next;
      s1 <= s0;
    end
  end

endmodule

// File: rtl/goertzel_multibin_power.sv
// Parallel Goertzel filters over a block of SIZE samples, followed by one shared
// re/im/power datapath that walks the bins two cycles each.
module goertzel_multibin_power
  import goertzel_pkg::*;
#(
  parameter int unsigned NUM_BINS   = 4,
  parameter int unsigned SIZE       = 64,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned COEFF_BITS = 24,
  parameter int unsigned ACC_W      = 32,
  parameter int unsigned FRAC_BITS  = 0,
  parameter int unsigned POW_W      = 32,
  localparam int unsigned COEFF_W   = coeff_width(COEFF_BITS),
  localparam int unsigned BIN_W     = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic                         abort_i,
  input  logic                         continuous_i,
  input  logic [NUM_BINS*COEFF_W-1:0]  cos_i,
  input  logic [NUM_BINS*COEFF_W-1:0]  sin_i,
  input  logic signed [DATA_W-1:0]     data_i,
  input  logic                         valid_i,
  output logic                         busy_o,
  output logic                         pow_valid_o,
  output logic [BIN_W-1:0]             pow_bin_o,
  output logic [POW_W-1:0]             pow_o,
  output logic                         done_o,
  output logic                         overrun_o
);

  localparam int unsigned CNT_W = $clog2(SIZE);
  localparam int unsigned SHIFT = FRAC_BITS + $clog2(SIZE) - 1;

  state_e state_q, state_d;
  logic [CNT_W-1:0]         cnt_q;
  logic [BIN_W-1:0]         bin_q;
  logic                     cont_q;
  logic                     overrun_q;
  logic signed [COEFF_W-1:0] cos_q [NUM_BINS];
  logic signed [COEFF_W-1:0] sin_q [NUM_BINS];
  logic signed [ACC_W-1:0]  s0 [NUM_BINS];
  logic signed [ACC_W-1:0]  s1 [NUM_BINS];
  logic signed [ACC_W-1:0]  re_q, im_q, re_d, im_d, mc, ms;
  logic [POW_W-1:0]         pow_q;
  logic [BIN_W-1:0]         pow_bin_q;
  logic                     pow_valid_q, done_q;
  logic [63:0]              pow_full;

  logic start_acc, clr, filt_valid, calc_a, calc_b, last_bin, last_sample;

  for (genvar k = 0; k < NUM_BINS; k++) begin : g_bin
    goertzel_bin_filter #(
      .DATA_W    (DATA_W),
      .COEFF_BITS(COEFF_BITS),
      .ACC_W     (ACC_W),
      .COEFF_W   (COEFF_W)
    ) u_filter (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .coeff(cos_q[k]),
      .data (data_i),
      .valid(filt_valid),
      .s0   (s0[k]),
      .s1   (s1[k])
    );
  end

  assign last_bin    = (bin_q == BIN_W'(NUM_BINS - 1));
  assign last_sample = (cnt_q == CNT_W'(SIZE - 1));

  always_comb begin
    state_d    = state_q;
    start_acc  = 1'b0;
    clr        = 1'b0;
    filt_valid = 1'b0;
    calc_a     = 1'b0;
    calc_b     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d   = StFilter;
          start_acc = 1'b1;
          clr       = 1'b1;
        end
      end
      StFilter: begin
        if (valid_i) begin
          filt_valid = 1'b1;
          if (last_sample) state_d = StCalcA;
        end
      end
      StCalcA: begin
        calc_a  = 1'b1;
        state_d = StCalcB;
      end
      StCalcB: begin
        calc_b = 1'b1;
        if (last_bin) begin
          state_d = cont_q ? StFilter : StIdle;
          clr     = cont_q;
        end else begin
          state_d = StCalcA;
        end
      end
      default: state_d = StIdle;
    endcase
    // Abort wins over everything, including strobes not yet registered.
    if (abort_i) begin
      state_d    = StIdle;
      start_acc  = 1'b0;
      clr        = 1'b0;
      filt_valid = 1'b0;
      calc_a     = 1'b0;
      calc_b     = 1'b0;
    end
  end

  always_comb begin
    mc       = ACC_W'(mulc(64'(cos_q[bin_q]), 64'(s0[bin_q]), COEFF_BITS));
    ms       = ACC_W'(mulc(64'(sin_q[bin_q]), 64'(s0[bin_q]), COEFF_BITS));
    re_d     = (mc - s1[bin_q]) >>> SHIFT;
    im_d     = ms >>> SHIFT;
    pow_full = sq_sum_sat(64'(re_q), 64'(im_q), POW_W);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bin_q       <= '0;
      cont_q      <= 1'b0;
      overrun_q   <= 1'b0;
      re_q        <= '0;
      im_q        <= '0;
      pow_q       <= '0;
      pow_bin_q   <= '0;
      pow_valid_q <= 1'b0;
      done_q      <= 1'b0;
      for (int k = 0; k < NUM_BINS; k++) begin
        cos_q[k] <= '0;
        sin_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      pow_valid_q <= 1'b0;
      done_q      <= 1'b0;
      if (start_acc) begin
        cont_q    <= continuous_i;
        overrun_q <= 1'b0;
        for (int k = 0; k < NUM_BINS; k++) begin
          cos_q[k] <= cos_i[k*COEFF_W +: COEFF_W];
          sin_q[k] <= sin_i[k*COEFF_W +: COEFF_W];
        end
      end
      if (cont_q && valid_i && (state_q == StCalcA || state_q == StCalcB)) overrun_q <= 1'b1;
      if (clr) cnt_q <= '0;
      else if (filt_valid) cnt_q <= cnt_q + 1'b1;
      if (filt_valid && last_sample) bin_q <= '0;
      if (calc_a) begin
        re_q <= re_d;
        im_q <= im_d;
      end
      if (calc_b) begin
        pow_q       <= pow_full[POW_W-1:0];
        pow_bin_q   <= bin_q;
        pow_valid_q <= 1'b1;
        done_q      <= last_bin;
        bin_q       <= last_bin ? '0 : bin_q + 1'b1;
      end
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign pow_valid_o = pow_valid_q;
  assign pow_bin_o   = pow_bin_q;
  assign pow_o       = pow_q;
  assign done_o      = done_q;
  assign overrun_o   = overrun_q;

endmodule
